// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter: FSM state encoding and data word.
package addsub_pkg;

   localparam int DATA_W = 16;

   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

endpackage

// File: rtl/addsub_arbiter_rr_select.sv
// Combinational requester selection: a valid lock owner wins, otherwise the first
// valid requester at or after rr_ptr_i, wrapping modulo NREQ.
module rr_select #(
   parameter int NREQ  = 2,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  valid_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   input  logic [IDX_W-1:0] lock_owner_i,
   input  logic             lock_active_i,
   output logic [IDX_W-1:0] sel_o,
   output logic             any_valid_o
);

   always_comb begin
      int idx;
      sel_o       = '0;
      any_valid_o = 1'b0;
      idx         = 0;
      if (lock_active_i && valid_i[lock_owner_i]) begin
         sel_o       = lock_owner_i;
         any_valid_o = 1'b1;
      end else begin
         // Scan from the farthest offset down so the nearest valid requester is assigned last.
         for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_i) + k) % NREQ;
            if (valid_i[idx[IDX_W-1:0]]) begin
               sel_o       = idx[IDX_W-1:0];
               any_valid_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one external 16-bit add/sub unit among NREQ requesters,
// with short locked bursts for dependent operations.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int NREQ     = 2,
   parameter int LOCK_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [DATA_W*NREQ-1:0] req_a,
   input  logic [DATA_W*NREQ-1:0] req_b,
   input  logic [NREQ-1:0]        req_sub,
   input  logic [NREQ-1:0]        req_lock,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output word_t                  rsp_sum,
   output logic                   rsp_cout,
   output logic                   rsp_ovfl,
   output word_t                  add_a,
   output word_t                  add_b,
   output logic                   add_sub,
   output logic                   add_cin,
   input  word_t                  add_s,
   input  logic                   add_cout,
   input  logic                   add_ovfl
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] lock_owner_q, lock_owner_d;
   logic             lock_active_q, lock_active_d;
   logic [3:0]       lock_cnt_q, lock_cnt_d;
   word_t            a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             sub_q, sub_d, lock_q, lock_d;
   logic             cout_q, cout_d, ovfl_q, ovfl_d;

   logic [IDX_W-1:0] sel;
   logic             any_valid;

   assign add_cin = 1'b0;

   rr_select #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_select (
      .valid_i       (req_valid),
      .rr_ptr_i      (rr_ptr_q),
      .lock_owner_i  (lock_owner_q),
      .lock_active_i (lock_active_q),
      .sel_o         (sel),
      .any_valid_o   (any_valid)
   );

   // NOTE: every variable gets its default before the case so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      lock_owner_d  = lock_owner_q;
      lock_active_d = lock_active_q;
      lock_cnt_d    = lock_cnt_q;
      a_d           = a_q;
      b_d           = b_q;
      sub_d         = sub_q;
      lock_d        = lock_q;
      sum_d         = sum_q;
      cout_d        = cout_q;
      ovfl_d        = ovfl_q;
      req_ready     = '0;
      rsp_valid     = '0;
      rsp_sum       = '0;
      rsp_cout      = 1'b0;
      rsp_ovfl      = 1'b0;
      add_a         = '0;
      add_b         = '0;
      add_sub       = 1'b0;

      case (state_q)
         IDLE: begin
            if (lock_active_q && !req_valid[lock_owner_q]) begin
               lock_active_d = 1'b0;
               lock_cnt_d    = '0;
            end
            // Gating with rst_n keeps the combinational ready low while reset is held.
            if (any_valid && rst_n) begin
               req_ready[sel] = 1'b1;
               grant_d        = sel;
               a_d            = req_a[int'(sel)*DATA_W +: DATA_W];
               b_d            = req_b[int'(sel)*DATA_W +: DATA_W];
               sub_d          = req_sub[sel];
               lock_d         = req_lock[sel];
               state_d        = EXEC;
            end
         end

         EXEC: begin
            add_a   = a_q;
            add_b   = b_q;
            add_sub = sub_q;
            sum_d   = add_s;
            cout_d  = add_cout;
            ovfl_d  = add_ovfl;
            state_d = RESP;
         end

         RESP: begin
            rsp_valid[grant_q] = 1'b1;
            rsp_sum            = sum_q;
            rsp_cout           = cout_q;
            rsp_ovfl           = ovfl_q;
            if (rsp_ready[grant_q]) begin
               state_d = IDLE;
               if (lock_q && (({1'b0, lock_cnt_q} + 5'd1) < 5'(LOCK_MAX))) begin
                  lock_owner_d  = grant_q;
                  lock_active_d = 1'b1;
                  lock_cnt_d    = lock_cnt_q + 4'd1;
               end else begin
                  lock_active_d = 1'b0;
                  lock_cnt_d    = '0;
                  rr_ptr_d      = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         lock_owner_q  <= '0;
         lock_active_q <= 1'b0;
         lock_cnt_q    <= '0;
         a_q           <= '0;
         b_q           <= '0;
         sub_q         <= 1'b0;
         lock_q        <= 1'b0;
         sum_q         <= '0;
         cout_q        <= 1'b0;
         ovfl_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         lock_owner_q  <= lock_owner_d;
         lock_active_q <= lock_active_d;
         lock_cnt_q    <= lock_cnt_d;
         a_q           <= a_d;
         b_q           <= b_d;
         sub_q         <= sub_d;
         lock_q        <= lock_d;
         sum_q         <= sum_d;
         cout_q        <= cout_d;
         ovfl_q        <= ovfl_d;
      end
   end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 16-bit carry-lookahead add/sub unit among NREQ requesters.
- Per requester: accepts an operation through a valid/ready handshake, registers the operands, drives the shared adder, and captures its sum, carry-out and overflow.
- Returns the result through a per-requester valid/ready response channel.
- Supports short locked bursts so one requester can keep the adder for consecutive dependent operations.

Parameters:
NREQ, 2, number of requesters (2..8)
LOCK_MAX, 4, maximum consecutive locked operations before a forced rotation (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accepted this cycle (at most one bit set)
req_a  in  16*NREQ  operand A, requester i at bits [16i+15:16i]
req_b  in  16*NREQ  operand B, same packing
req_sub  in  NREQ  1 = A-B, 0 = A+B
req_lock  in  NREQ  keep the grant after this operation completes
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  response consumed
rsp_sum  out  16  result, shared by all requesters
rsp_cout  out  1  adder carry-out
rsp_ovfl  out  1  adder signed overflow
add_a  out  16  to shared adder A
add_b  out  16  to shared adder Bin (uninverted)
add_sub  out  1  to shared adder isSub; this is the adder's effective carry-in
add_cin  out  1  to shared adder Cin; tied 0, the adder ignores it
add_s  in  16  from shared adder S
add_cout  in  1  from shared adder Cout
add_ovfl  in  1  from shared adder ovfl

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, rr_ptr=0, lock_owner cleared, lock_cnt=0.
  - All outputs 0.
  - Any in-flight operation is dropped; no response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Selection: if a lock is active and the owner's req_valid=1, select the owner. Otherwise select the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  - If the lock owner has req_valid=0 in IDLE, the lock is released that cycle and normal selection applies.
  - req_ready[sel] is asserted combinationally in the same cycle. Operands, sub, lock and the grant index are registered. Next state is EXEC.
  - No requester is valid: stay in IDLE, all outputs 0.
- EXEC (one cycle):
  - add_a, add_b and add_sub are driven from the operand registers and held stable all cycle.
  - On the clock edge, add_s, add_cout and add_ovfl are captured into the result registers. Next state is RESP.
  - Outside EXEC, add_a, add_b and add_sub are held at 0.
- RESP:
  - rsp_valid[grant]=1; rsp_sum, rsp_cout and rsp_ovfl stay stable until the cycle with rsp_ready[grant]=1.
  - On that handshake, go to IDLE and update the lock:
    - Registered lock=1 and lock_cnt+1 < LOCK_MAX: lock_owner=grant, lock_cnt increments, rr_ptr unchanged.
    - Otherwise: clear the lock, set lock_cnt=0, set rr_ptr=grant+1 mod NREQ.
  - rsp_ready of non-granted requesters is ignored.
- Latency and throughput:
  - Request accepted at cycle T; rsp_valid is first high in cycle T+2.
  - Peak throughput is one operation per 3 cycles when rsp_ready is held high.
- Arithmetic:
  - Pure pass-through; the block never modifies the adder's results.
  - Subtraction carry-out follows two's-complement convention: 1 means no borrow.
  - Overflow is the adder's own signed overflow flag.
- Simultaneous events:
  - Several requesters valid: exactly one is granted per accept.
  - req_valid dropping while not ready is legal; the request is simply not taken.
  - Operand changes while req_ready=0 have no effect.
- Starvation bound: a requester that keeps req_valid high waits at most NREQ*LOCK_MAX operations.

Decomposition:
- Shared package addsub_pkg holds:
  - The FSM state enum (IDLE/EXEC/RESP).
  - The constant DATA_W=16.
  - A typedef for the operand/result word.
- Natural sub-module: rr_select. It is combinational; inputs are valid vector, rr_ptr, lock_owner and lock_active; outputs are the selected index and an any-valid flag.
- The shared adder is instantiated outside this block and connected through the add_* ports.

Test Plan:
- Single add: req0 A=0x0005, B=0x0003, sub=0, rsp_ready=1 -> rsp_valid[0] in cycle T+2; sum=0x0008, cout=0, ovfl=0.
- Subtract with borrow and overflow:
  - req1 0x0003-0x0005 -> sum=0xFFFE, cout=0, ovfl=0.
  - req1 0x7FFF+0x0001 -> sum=0x8000, ovfl=1.
  - req1 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovfl=1.
- Contention: req0 and req1 valid from reset and held -> grants alternate 0,1,0,1; at most one req_ready per cycle; every operation takes 3 cycles.
- Lock and LOCK_MAX: req1 lock=1 continuously, req0 valid -> req1 granted 4 consecutive times, then req0. With req1 lock=0 on its second operation, req0 is granted after that second operation.
- Response stall: rsp_ready[0]=0 for 5 cycles -> rsp_valid and sum held stable; req1 is not accepted until the handshake completes.
- Reset mid-operation: assert rst_n=0 during EXEC -> all outputs 0 immediately; no rsp_valid after release; the next request is granted to requester 0 first.
